mem_refill_arbiter: RTL and testbench

- Shares the single 128-bit main-memory refill port between NUM_REQ cache clients, such as the I-cache and a line prefetcher.
- Each client raises a line-refill request. The arbiter selects one client round-robin, drives the mem_req/mem_addr/mem_ready handshake, and returns the line to that client only.
- A watchdog aborts refills that memory never answers and reports an error to the owning client.

---
 rtl/cache_pkg.sv | 14 +
 rtl/mem_refill_arbiter_rr_picker.sv | 33 +++
 rtl/mem_refill_arbiter.sv | 112 +++++++++++
 tb/tb_mem_refill_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-side constants and types used by the refill arbiter and its helpers.
package cache_pkg;

  localparam int LINE_BITS        = 128;
  localparam int ADDR_BITS        = 32;
  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_refill_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping to 0.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int         cand;
    logic [IDX_W-1:0] cand_idx;
    logic       found;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing the main-memory refill port between cache clients,
// with a watchdog that aborts refills memory never answers.
module mem_refill_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [LINE_BITS-1:0]         resp_data,
  output logic                         resp_err,
  output logic                         mem_req,
  output logic [ADDR_BITS-1:0]         mem_addr,
  input  logic [LINE_BITS-1:0]         mem_data_in,
  input  logic                         mem_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic WD_EN = (TIMEOUT != 0);
  localparam logic [ADDR_BITS-1:0] OFFSET_MASK = ADDR_BITS'((1 << LINE_OFFSET_BITS) - 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     owner;
  logic [CNT_W-1:0]     wd_cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic [ADDR_BITS-1:0] sel_addr;
  logic                 wd_expired;
  logic [IDX_W-1:0]     next_ptr;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Gating with rst keeps the accept strobe low while reset is held.
  assign req_ready  = (rst && state == IDLE) ? pick_grant : '0;
  assign mem_addr   = addr_q;
  assign wd_expired = WD_EN && (wd_cnt == CNT_LAST);
  assign next_ptr   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      wd_cnt     <= '0;
      addr_q     <= '0;
      mem_req    <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            owner   <= pick_idx;
            addr_q  <= sel_addr & ~OFFSET_MASK;
            wd_cnt  <= '0;
            mem_req <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          // Data arriving on the final watchdog cycle still counts as a good refill.
          if (mem_ready) begin
            resp_data  <= mem_data_in;
            resp_err   <= 1'b0;
            resp_valid <= NUM_REQ'(1) << owner;
            mem_req    <= 1'b0;
            state      <= RESP;
          end else if (wd_expired) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= NUM_REQ'(1) << owner;
            mem_req    <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= '0;
          rr_ptr     <= next_ptr;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: a cycle table for the common flows plus
// hand sequences for the watchdog, timeout race, reset and spurious-ready cases.
module tb_mem_refill_arbiter;
  import cache_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 8;
  localparam logic [127:0] DATA_A5 = {16{8'hA5}};
  localparam logic [127:0] DATA_5A = {16{8'h5A}};

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [63:0]  req_addr;
  logic [1:0]   req_ready;
  logic [1:0]   resp_valid;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data_in;
  logic         mem_ready;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic         rst;
    logic [1:0]   req;
    logic [31:0]  a0;
    logic [31:0]  a1;
    logic         mr;
    logic [127:0] md;
    logic [1:0]   e_ready;
    logic         e_mreq;
    logic [31:0]  e_addr;
    logic [1:0]   e_rv;
    logic         e_err;
    logic [127:0] e_data;
  } vec_t;

  vec_t vecs[$];

  mem_refill_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data_in(mem_data_in),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] bench did not terminate");
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [1:0] req, input logic [31:0] a0,
                                input logic [31:0] a1, input logic mr, input logic [127:0] md);
    rst         = r;
    req_valid   = req;
    req_addr    = {a1, a0};
    mem_ready   = mr;
    mem_data_in = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic [1:0] req, input logic [31:0] a0,
                         input logic [31:0] a1, input logic mr, input logic [127:0] md,
                         input logic [1:0] e_ready, input logic e_mreq, input logic [31:0] e_addr,
                         input logic [1:0] e_rv, input logic e_err, input logic [127:0] e_data);
    vecs.push_back('{r, req, a0, a1, mr, md, e_ready, e_mreq, e_addr, e_rv, e_err, e_data});
  endtask

  initial begin
    // Single request, refill answered on the third BUSY cycle.
    add_vec(1, 2'b01, 32'h1234, 32'h0, 0, 128'h0,   2'b01, 0, 32'h0,    2'b00, 0, 128'h0);
    add_vec(1, 2'b00, 32'h1234, 32'h0, 0, 128'h0,   2'b00, 1, 32'h1230, 2'b00, 0, 128'h0);
    add_vec(1, 2'b00, 32'h1234, 32'h0, 0, 128'h0,   2'b00, 1, 32'h1230, 2'b00, 0, 128'h0);
    add_vec(1, 2'b00, 32'h1234, 32'h0, 1, DATA_A5,  2'b00, 1, 32'h1230, 2'b00, 0, 128'h0);
    add_vec(1, 2'b00, 32'h1234, 32'h0, 0, 128'h0,   2'b00, 0, 32'h0,    2'b01, 0, DATA_A5);
    add_vec(1, 2'b00, 32'h1234, 32'h0, 0, 128'h0,   2'b00, 0, 32'h0,    2'b00, 0, DATA_A5);
    // Reset, then both clients requesting continuously.
    add_vec(0, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b00, 0, 32'h0,    2'b00, 0, 128'h0);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b01, 0, 32'h0,    2'b00, 0, 128'h0);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 1, 128'h1, 2'b00, 1, 32'h1000, 2'b00, 0, 128'h0);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b00, 0, 32'h0,    2'b01, 0, 128'h1);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b10, 0, 32'h0,    2'b00, 0, 128'h1);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 1, 128'h2, 2'b00, 1, 32'h2000, 2'b00, 0, 128'h1);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b00, 0, 32'h0,    2'b10, 0, 128'h2);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b01, 0, 32'h0,    2'b00, 0, 128'h2);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 1, 128'h3, 2'b00, 1, 32'h1000, 2'b00, 0, 128'h2);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b00, 0, 32'h0,    2'b01, 0, 128'h3);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 0, 128'h0, 2'b10, 0, 32'h0,    2'b00, 0, 128'h3);
    add_vec(1, 2'b11, 32'h100F, 32'h2008, 1, 128'h4, 2'b00, 1, 32'h2000, 2'b00, 0, 128'h3);
    add_vec(1, 2'b00, 32'h100F, 32'h2008, 0, 128'h0, 2'b00, 0, 32'h0,    2'b10, 0, 128'h4);
    add_vec(1, 2'b00, 32'h100F, 32'h2008, 0, 128'h0, 2'b00, 0, 32'h0,    2'b00, 0, 128'h4);

    apply_stimulus(0, 2'b00, 32'h0, 32'h0, 0, 128'h0);
    tick();
    tick();
    check_output("reset req_ready", 128'(req_ready), 128'h0);
    check_output("reset resp_valid", 128'(resp_valid), 128'h0);
    check_output("reset resp_data", resp_data, 128'h0);
    check_output("reset resp_err", 128'(resp_err), 128'h0);
    check_output("reset mem_req", 128'(mem_req), 128'h0);
    check_output("reset mem_addr", 128'(mem_addr), 128'h0);
    apply_stimulus(1, 2'b00, 32'h0, 32'h0, 0, 128'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].mr, vecs[i].md);
      check_output($sformatf("v%0d req_ready", i), 128'(req_ready), 128'(vecs[i].e_ready));
      check_output($sformatf("v%0d mem_req", i), 128'(mem_req), 128'(vecs[i].e_mreq));
      if (vecs[i].e_mreq)
        check_output($sformatf("v%0d mem_addr", i), 128'(mem_addr), 128'(vecs[i].e_addr));
      check_output($sformatf("v%0d resp_valid", i), 128'(resp_valid), 128'(vecs[i].e_rv));
      check_output($sformatf("v%0d resp_err", i), 128'(resp_err), 128'(vecs[i].e_err));
      check_output($sformatf("v%0d resp_data", i), resp_data, vecs[i].e_data);
      tick();
    end

    // Watchdog: memory silent, mem_req must stay up exactly TIMEOUT cycles.
    apply_stimulus(1, 2'b01, 32'h3004, 32'h0, 0, 128'h0);
    check_output("to grant", 128'(req_ready), 128'h1);
    tick();
    apply_stimulus(1, 2'b00, 32'h3004, 32'h0, 0, 128'h0);
    for (int c = 0; c < TIMEOUT; c++) begin
      check_output($sformatf("to mem_req c%0d", c), 128'(mem_req), 128'h1);
      check_output($sformatf("to mem_addr c%0d", c), 128'(mem_addr), 128'h3000);
      check_output($sformatf("to resp_valid c%0d", c), 128'(resp_valid), 128'h0);
      tick();
    end
    check_output("to end mem_req", 128'(mem_req), 128'h0);
    check_output("to resp_valid", 128'(resp_valid), 128'h1);
    check_output("to resp_err", 128'(resp_err), 128'h1);
    check_output("to resp_data", resp_data, 128'h0);
    tick();
    apply_stimulus(1, 2'b10, 32'h0, 32'h4008, 0, 128'h0);
    check_output("after_to grant", 128'(req_ready), 128'h2);
    tick();
    apply_stimulus(1, 2'b00, 32'h0, 32'h4008, 1, 128'h7);
    check_output("after_to mem_addr", 128'(mem_addr), 128'h4000);
    tick();
    apply_stimulus(1, 2'b00, 32'h0, 32'h4008, 0, 128'h0);
    check_output("after_to resp_valid", 128'(resp_valid), 128'h2);
    check_output("after_to resp_err", 128'(resp_err), 128'h0);
    check_output("after_to resp_data", resp_data, 128'h7);
    tick();

    // Data arriving on the last watchdog cycle beats the timeout.
    apply_stimulus(1, 2'b01, 32'h5000, 32'h0, 0, 128'h0);
    check_output("race grant", 128'(req_ready), 128'h1);
    tick();
    apply_stimulus(1, 2'b00, 32'h5000, 32'h0, 0, 128'h0);
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      check_output($sformatf("race mem_req c%0d", c), 128'(mem_req), 128'h1);
      tick();
    end
    apply_stimulus(1, 2'b00, 32'h5000, 32'h0, 1, DATA_5A);
    check_output("race last mem_req", 128'(mem_req), 128'h1);
    tick();
    apply_stimulus(1, 2'b00, 32'h5000, 32'h0, 0, 128'h0);
    check_output("race resp_valid", 128'(resp_valid), 128'h1);
    check_output("race resp_err", 128'(resp_err), 128'h0);
    check_output("race resp_data", resp_data, DATA_5A);
    tick();

    // Reset in the middle of a refill to client1.
    apply_stimulus(1, 2'b10, 32'h0, 32'h6000, 0, 128'h0);
    check_output("rst grant", 128'(req_ready), 128'h2);
    tick();
    apply_stimulus(1, 2'b00, 32'h0, 32'h6000, 0, 128'h0);
    check_output("rst busy mem_req", 128'(mem_req), 128'h1);
    apply_stimulus(0, 2'b00, 32'h0, 32'h6000, 0, 128'h0);
    check_output("rst async mem_req", 128'(mem_req), 128'h0);
    check_output("rst async resp_data", resp_data, 128'h0);
    tick();
    apply_stimulus(1, 2'b00, 32'h0, 32'h0, 0, 128'h0);
    check_output("rst release resp_valid", 128'(resp_valid), 128'h0);
    tick();
    check_output("rst post resp_valid", 128'(resp_valid), 128'h0);
    check_output("rst post mem_req", 128'(mem_req), 128'h0);
    apply_stimulus(1, 2'b11, 32'h7000, 32'h8000, 0, 128'h0);
    check_output("rst next grant", 128'(req_ready), 128'h1);
    tick();
    apply_stimulus(1, 2'b00, 32'h7000, 32'h8000, 1, 128'h8);
    check_output("rst next mem_addr", 128'(mem_addr), 128'h7000);
    tick();
    apply_stimulus(1, 2'b00, 32'h7000, 32'h8000, 0, 128'h0);
    check_output("rst next resp_valid", 128'(resp_valid), 128'h1);
    check_output("rst next resp_data", resp_data, 128'h8);
    tick();

    // Spurious mem_ready while idle, then client1 withdraws before it is granted.
    apply_stimulus(1, 2'b00, 32'h0, 32'h0, 1, 128'hFF);
    check_output("spur req_ready", 128'(req_ready), 128'h0);
    tick();
    check_output("spur mem_req", 128'(mem_req), 128'h0);
    check_output("spur resp_valid", 128'(resp_valid), 128'h0);
    check_output("spur resp_data", resp_data, 128'h8);
    tick();
    check_output("spur2 resp_valid", 128'(resp_valid), 128'h0);
    apply_stimulus(1, 2'b01, 32'h9000, 32'h0, 0, 128'h0);
    check_output("wd grant0", 128'(req_ready), 128'h1);
    tick();
    apply_stimulus(1, 2'b11, 32'h9000, 32'hA000, 0, 128'h0);
    check_output("wd busy req_ready", 128'(req_ready), 128'h0);
    check_output("wd busy mem_req", 128'(mem_req), 128'h1);
    apply_stimulus(1, 2'b11, 32'h9000, 32'hA000, 1, 128'h9);
    tick();
    apply_stimulus(1, 2'b01, 32'h9000, 32'h0, 0, 128'h0);
    check_output("wd resp_valid", 128'(resp_valid), 128'h1);
    check_output("wd resp req_ready", 128'(req_ready), 128'h0);
    tick();
    apply_stimulus(1, 2'b01, 32'h9000, 32'h0, 1, 128'hEE);
    check_output("wd no grant to withdrawn", 128'(req_ready), 128'h1);
    tick();
    apply_stimulus(1, 2'b00, 32'h9000, 32'h0, 0, 128'h0);
    check_output("wd accept resp_valid", 128'(resp_valid), 128'h0);
    check_output("wd accept mem_addr", 128'(mem_addr), 128'h9000);
    apply_stimulus(1, 2'b00, 32'h9000, 32'h0, 1, 128'h10);
    tick();
    apply_stimulus(1, 2'b00, 32'h9000, 32'h0, 0, 128'h0);
    check_output("wd final resp_valid", 128'(resp_valid), 128'h1);
    check_output("wd final resp_data", resp_data, 128'h10);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
